dmem_arbiter: RTL

//  Shares the single-port data memory between the pipeline MEM stage and a DMA/program-loader

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_sat_counter.sv | 38 +++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Owner encoding, default limits and a counter-width helper.
package dmem_arbiter_pkg;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_WAIT_MAX  = 8;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline MEM stage has priority,
// DMA gets idle cycles or a forced slot after starving.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int WAIT_MAX  = DEF_WAIT_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m_req,
    input  logic          m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_wdata,
    output logic [DW-1:0] m_rdata,
    output logic          pipe_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = cnt_width(WAIT_MAX);
    localparam int BW = cnt_width(MAX_BURST - 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(WAIT_MAX - 1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);

    owner_e state_q;
    owner_e state_d;
    logic          d_rvalid_q;
    logic          d_rvalid_d;
    logic [DW-1:0] d_rdata_q;
    logic [DW-1:0] d_rdata_d;

    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt;
    logic          starve_inc;
    logic          starve_clr;
    logic          burst_inc;
    logic          burst_clr;

    assign starve_inc = (state_q == OWN_PIPE) && d_req && m_req;
    assign starve_clr = (state_q == OWN_DMA) || !d_req;
    assign burst_inc  = (state_q == OWN_DMA) && d_req;
    assign burst_clr  = (state_q == OWN_PIPE);

    arb_sat_counter #(
        .WIDTH (SW),
        .MAX   (WAIT_MAX)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .cnt (starve_cnt)
    );

    arb_sat_counter #(
        .WIDTH (BW),
        .MAX   (MAX_BURST - 1)
    ) u_burst_cnt (
        .clk (clk),
        .rst (rst),
        .inc (burst_inc),
        .clr (burst_clr),
        .cnt (burst_cnt)
    );

    always_comb begin
        state_d    = state_q;
        mem_addr   = m_addr;
        mem_wdata  = m_wdata;
        mem_we     = 1'b0;
        d_gnt      = 1'b0;
        pipe_stall = 1'b0;
        unique case (state_q)
            OWN_PIPE: begin
                mem_we = m_req && m_we;
                if (d_req && (!m_req || (starve_cnt == STARVE_LAST))) begin
                    state_d = OWN_DMA;
                end
            end
            OWN_DMA: begin
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
                mem_we     = d_req && d_we;
                d_gnt      = d_req;
                pipe_stall = m_req;
                if (!d_req || ((burst_cnt == BURST_LAST) && m_req)) begin
                    state_d = OWN_PIPE;
                end
            end
            default: state_d = OWN_PIPE;
        endcase
        // Reset aborts any in-flight DMA access before it reaches memory.
        if (rst) begin
            mem_we  = 1'b0;
            d_gnt   = 1'b0;
            state_d = OWN_PIPE;
        end
    end

    always_comb begin
        d_rvalid_d = d_gnt && !d_we;
        d_rdata_d  = d_rvalid_d ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OWN_PIPE;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_rdata  = mem_rdata;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;

endmodule
